// File: rtl/stackcalc_pkg.sv
// Shared opcodes, FSM state type and default geometry for the RPN stack calculator.
package stackcalc_pkg;

  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned DATA_WIDTH  = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_DROP = 4'h2;
  localparam logic [3:0] OP_DUP  = 4'h3;
  localparam logic [3:0] OP_SWAP = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_INC  = 4'hB;
  localparam logic [3:0] OP_DEC  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_CLR  = 4'hF;

  typedef enum logic {
    EXEC = 1'b0,
    LIT  = 1'b1
  } state_e;

endpackage

// File: rtl/stackcalc_alu.sv
// Combinational ALU: computes the result, carry and operand requirement of one opcode.
module stackcalc_alu
  import stackcalc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] n,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             carry_en,
  output logic [1:0]       operands
);

  // Opcode decode: binary ops produce N op T, unary ops act on T.
  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    carry_en  = 1'b0;
    operands  = 2'd0;
    case (op)
      OP_DROP, OP_DUP: operands = 2'd1;
      OP_SWAP:         operands = 2'd2;
      OP_ADD: begin
        operands              = 2'd2;
        carry_en              = 1'b1;
        {carry_out, result}   = {1'b0, n} + {1'b0, t};
      end
      OP_SUB: begin
        operands              = 2'd2;
        carry_en              = 1'b1;
        {carry_out, result}   = {1'b0, n} - {1'b0, t};
      end
      OP_AND: begin
        operands = 2'd2;
        result   = n & t;
      end
      OP_OR: begin
        operands = 2'd2;
        result   = n | t;
      end
      OP_XOR: begin
        operands = 2'd2;
        result   = n ^ t;
      end
      OP_NOT: begin
        operands = 2'd1;
        result   = ~t;
      end
      OP_INC: begin
        operands              = 2'd1;
        carry_en              = 1'b1;
        {carry_out, result}   = {1'b0, t} + (WIDTH+1)'(1);
      end
      OP_DEC: begin
        operands              = 2'd1;
        carry_en              = 1'b1;
        {carry_out, result}   = {1'b0, t} - (WIDTH+1)'(1);
      end
      OP_SHL: begin
        operands  = 2'd1;
        carry_en  = 1'b1;
        carry_out = t[WIDTH-1];
        result    = {t[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        operands  = 2'd1;
        carry_en  = 1'b1;
        carry_out = t[0];
        result    = {1'b0, t[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/davidsiaw_stack_calc.sv
// 4-bit RPN stack calculator behind an 8-in/8-out pad slot.
module davidsiaw_stack_calc
  import stackcalc_pkg::*;
#(
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  logic             clk;
  logic             rst;
  logic [3:0]       ins;
  logic             unused_pins;

  assign clk         = io_in[0];
  assign rst         = io_in[1];
  assign ins         = io_in[5:2];
  assign unused_pins = ^io_in[7:6];

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  state_e           state_q, state_d;

  logic [AW-1:0]    t_idx, n_idx, p_idx;
  logic [WIDTH-1:0] t_val, n_val;
  logic             full, empty;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_carry_en;
  logic [1:0]       alu_operands;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign p_idx = depth_q[AW-1:0];
  assign t_idx = p_idx - AW'(1);
  assign n_idx = p_idx - AW'(2);
  assign t_val = (depth_q >= DW'(1)) ? stack_q[t_idx] : '0;
  assign n_val = (depth_q >= DW'(2)) ? stack_q[n_idx] : '0;

  stackcalc_alu #(.WIDTH(WIDTH)) u_alu (
    .t         (t_val),
    .n         (n_val),
    .op        (ins),
    .result    (alu_result),
    .carry_out (alu_carry),
    .carry_en  (alu_carry_en),
    .operands  (alu_operands)
  );

  // Next-state: literal capture in LIT, opcode execution with error checks in EXEC.
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    carry_d = carry_q;
    err_d   = err_q;
    state_d = state_q;
    unique case (state_q)
      LIT: begin
        state_d = EXEC;
        if (full) begin
          err_d = 1'b1;
        end else begin
          stack_d[p_idx] = ins;
          depth_d        = depth_q + DW'(1);
        end
      end
      EXEC: begin
        if (depth_q < DW'(alu_operands)) begin
          err_d = 1'b1;
        end else begin
          if (alu_carry_en) carry_d = alu_carry;
          case (ins)
            OP_PUSH: state_d = LIT;
            OP_DROP: depth_d = depth_q - DW'(1);
            OP_DUP: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                stack_d[p_idx] = t_val;
                depth_d        = depth_q + DW'(1);
              end
            end
            OP_SWAP: begin
              stack_d[t_idx] = n_val;
              stack_d[n_idx] = t_val;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              stack_d[n_idx] = alu_result;
              depth_d        = depth_q - DW'(1);
            end
            OP_NOT, OP_INC, OP_DEC, OP_SHL, OP_SHR: stack_d[t_idx] = alu_result;
            OP_CLR: begin
              depth_d = '0;
              carry_d = 1'b0;
              err_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_q <= '{default: '0};
      depth_q <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      state_q <= EXEC;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign io_out = {empty, full, err_q, carry_q, (empty ? '0 : t_val)};

endmodule

// File: tb/tb_davidsiaw_stack_calc.sv
// Bench for davidsiaw_stack_calc: directed scenarios plus random opcode streams vs a queue model.
module tb_davidsiaw_stack_calc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ins = 4'h0;
  logic [1:0] junk = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int stk[$];
  bit m_carry;
  bit m_err;
  bit m_lit;

  assign io_in = {junk, ins, rst, clk};

  always #5 clk = ~clk;

  davidsiaw_stack_calc dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: io_out=%02h expected bench completion", io_out);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] exp);
    tests++;
    assert (io_out === exp) else begin
      fails++;
      $error("FAIL %s: io_out=%02h expected %02h", tag, io_out, exp);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] tos;
    tos = (stk.size() == 0) ? 4'h0 : 4'(stk[$]);
    return {stk.size() == 0, stk.size() == 8, m_err, m_carry, tos};
  endfunction

  function automatic void model_reset();
    stk.delete();
    m_carry = 1'b0;
    m_err   = 1'b0;
    m_lit   = 1'b0;
  endfunction

  function automatic void model_exec(input int v);
    int need, t, n, r;
    if (m_lit) begin
      m_lit = 1'b0;
      if (stk.size() == 8) m_err = 1'b1;
      else stk.push_back(v);
      return;
    end
    if (v inside {2, 3, [10:14]}) need = 1;
    else if (v inside {[4:9]}) need = 2;
    else need = 0;
    if (stk.size() < need) begin
      m_err = 1'b1;
      return;
    end
    case (v)
      1: m_lit = 1'b1;
      2: void'(stk.pop_back());
      3: if (stk.size() == 8) m_err = 1'b1; else stk.push_back(stk[$]);
      4: begin
        t = stk.pop_back(); n = stk.pop_back();
        stk.push_back(t); stk.push_back(n);
      end
      5, 6, 7, 8, 9: begin
        t = stk.pop_back(); n = stk.pop_back();
        case (v)
          5: begin r = n + t; m_carry = (r > 15); end
          6: begin r = n - t; m_carry = (n < t); end
          7: r = n & t;
          8: r = n | t;
          default: r = n ^ t;
        endcase
        stk.push_back(r & 15);
      end
      10, 11, 12, 13, 14: begin
        t = stk.pop_back();
        case (v)
          10: r = 15 - t;
          11: begin r = t + 1; m_carry = (t == 15); end
          12: begin r = t - 1; m_carry = (t == 0); end
          13: begin r = t * 2; m_carry = (t >= 8); end
          default: begin r = t / 2; m_carry = (t % 2 == 1); end
        endcase
        stk.push_back(r & 15);
      end
      15: begin
        stk.delete();
        m_carry = 1'b0;
        m_err   = 1'b0;
      end
      default: ;
    endcase
  endfunction

  // Apply one nibble for one clock and compare against the model.
  task automatic step(input int v);
    @(negedge clk);
    ins  = 4'(v);
    junk = 2'($urandom);
    @(posedge clk);
    model_exec(v);
    #1;
    check("model", model_out());
  endtask

  // Asynchronous reset pulse away from the clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", 8'h80);
    model_reset();
    @(negedge clk);
    ins = 4'h0;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 check("rst_level", 8'h80);
    repeat (2) @(posedge clk);
    #1 check("rst_held", 8'h80);
    @(negedge clk);
    rst = 1'b0;

    repeat (3) step(0);
    check("nop_after_rst", 8'h80);

    step(1); step(3); step(1); step(5); step(5);
    check("add_3_5", 8'h08);
    step(1); step(9); step(5);
    check("add_carry", 8'h11);

    step(15);
    check("clr1", 8'h80);
    step(1); step(2); step(1); step(7); step(6);
    check("sub_borrow", 8'h1B);
    step(4);
    check("swap_underflow", 8'h3B);
    step(15);
    check("clr2", 8'h80);

    for (int i = 0; i < 8; i++) begin
      step(1); step(1);
    end
    check("full", 8'h41);
    step(1); step(1);
    check("push_overflow", 8'h61);
    step(3);
    check("dup_overflow", 8'h61);
    repeat (8) step(2);
    check("drained", 8'hA0);

    step(1); step(8); step(13);
    check("shl", 8'h30);
    step(14);
    check("shr_zero", 8'h20);
    step(12);
    check("dec_zero", 8'h3F);

    step(1);
    do_reset();
    step(5);
    check("rst_mid_push", 8'hA0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        step(1);
        step(int'($urandom_range(0, 15)));
      end else begin
        step(int'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
